// File: rtl/irq_ctrl_if.sv
// Register-bus port of the interrupt controller: word-select, write strobe and data.
// The slave drives rdata combinationally from addr.
interface irq_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises device lines and latches them as edge/level pending bits.
// Masks and fixed-priority arbitrates them, then sequences one request to the CPU.
module irq_ctrl #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  irq_ctrl_if.slave        bus,
  output logic [N_SRC-1:0] hwint,
  output logic             irq,
  output logic [2:0]       irq_id,
  input  logic             ack
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_INSVC = 2'd2;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] hwint_q, hwint_d;
  logic [IW-1:0]    cur_id_q, cur_id_d;
  logic [1:0]       state_q, state_d;

  logic [N_SRC-1:0] act_c, rise_c, w1c_c, eoi_clr_c;
  logic [IW-1:0]    win_c;
  logic             any_c, eoi_hit_c;
  logic             unused_wdata;

  assign unused_wdata = ^bus.wdata;

  // Fixed-priority winner: lowest active index.
  always_comb begin
    act_c = pend_q & mask_q;
    any_c = |act_c;
    win_c = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (act_c[i]) win_c = IW'(i);
    end
  end

  // Pending, mask and mode register updates; an edge set beats a same-cycle clear.
  always_comb begin
    rise_c    = s2_q & ~s3_q;
    w1c_c     = (bus.we && bus.addr == A_PEND) ? bus.wdata[N_SRC-1:0] : '0;
    eoi_hit_c = bus.we && (bus.addr == A_EOI) && (state_q == ST_INSVC);
    eoi_clr_c = eoi_hit_c ? (N_SRC'(1) << cur_id_q) : '0;
    pend_d    = (mode_q & ((pend_q & ~(w1c_c | eoi_clr_c)) | rise_c)) | (~mode_q & s2_q);
    mask_d    = (bus.we && bus.addr == A_MASK) ? bus.wdata[N_SRC-1:0] : mask_q;
    mode_d    = (bus.we && bus.addr == A_MODE) ? bus.wdata[N_SRC-1:0] : mode_q;
    hwint_d   = act_c;
  end

  // Request sequencer: IDLE -> REQ -> INSVC -> IDLE.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d  = ST_REQ;
          cur_id_d = win_c;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_d = ST_INSVC;
        end else if (!any_c) begin
          state_d = ST_IDLE;
        end else begin
          cur_id_d = win_c;
        end
      end
      ST_INSVC: begin
        if (eoi_hit_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      hwint_q  <= '0;
      cur_id_q <= '0;
      state_q  <= ST_IDLE;
    end else begin
      s1_q     <= src;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      hwint_q  <= hwint_d;
      cur_id_q <= cur_id_d;
      state_q  <= state_d;
    end
  end

  assign hwint  = hwint_q;
  assign irq    = (state_q == ST_REQ);
  assign irq_id = cur_id_q;

  // Read mux; unimplemented upper bits read as zero.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      A_PEND:  bus.rdata = DW'(pend_q);
      A_MASK:  bus.rdata = DW'(mask_q);
      A_MODE:  bus.rdata = DW'(mode_q);
      default: bus.rdata = {22'b0, state_q, 5'b0, cur_id_q};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus queues expected values, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_irq_ctrl;

  typedef struct {
    string       name;
    int          sel;   // 0 irq, 1 irq_id, 2 hwint, 3 rdata
    logic [31:0] exp;
    logic [31:0] msk;
  } item_t;

  localparam logic [31:0] FULL = 32'hFFFF_FFFF;
  localparam logic [31:0] STM  = 32'h0000_0300;

  logic       clk;
  logic       reset;
  logic [5:0] src;
  logic [5:0] hwint;
  logic       irq;
  logic [2:0] irq_id;
  logic       ack;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .src    (src),
    .bus    (bus),
    .hwint  (hwint),
    .irq    (irq),
    .irq_id (irq_id),
    .ack    (ack)
  );

  item_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: compare every queued expectation against the DUT at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t       it;
      logic [31:0] obs;
      it = sb.pop_front();
      case (it.sel)
        0:       obs = {31'b0, irq};
        1:       obs = 32'(irq_id);
        2:       obs = 32'(hwint);
        default: obs = bus.rdata;
      endcase
      n_vec++;
      if ((obs & it.msk) !== (it.exp & it.msk)) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h want 0x%08h", it.name, obs & it.msk, it.exp & it.msk);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_o(input string nm, input int sel, input logic [31:0] v);
    item_t it;
    it.name = nm; it.sel = sel; it.exp = v; it.msk = FULL;
    sb.push_back(it);
  endtask

  task automatic exp_rd(input string nm, input logic [1:0] a, input logic [31:0] v,
                        input logic [31:0] m);
    item_t it;
    bus.addr = a;
    it.name = nm; it.sel = 3; it.exp = v; it.msk = m;
    sb.push_back(it);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.we    = 1'b1;
    bus.wdata = d;
    cyc();
    bus.we    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; src = 6'h3F; ack = 1'b0;
    bus.addr = 2'd0; bus.we = 1'b0; bus.wdata = '0;
    cyc(); cyc();

    // T1: reset state while all lines are high
    exp_o("t1_irq", 0, 0); exp_o("t1_irq_id", 1, 0); exp_o("t1_hwint", 2, 0);
    exp_rd("t1_pend", 2'd0, 0, FULL); cyc();
    exp_rd("t1_mask", 2'd1, 0, FULL); cyc();
    exp_rd("t1_mode", 2'd2, 0, FULL); cyc();
    exp_rd("t1_eoi",  2'd3, 0, FULL); cyc();
    reset = 1'b1;
    cyc(); cyc(); cyc();
    exp_rd("t1_pend_level", 2'd0, 32'h3F, FULL);
    exp_o("t1_irq_masked", 0, 0); exp_o("t1_hwint_masked", 2, 0); cyc();

    // T2: single edge source, W1C withdraws request
    src = 6'h00; cyc(); cyc(); cyc();
    wr(2'd2, 32'h01); wr(2'd1, 32'h01);
    src = 6'h01; cyc(); src = 6'h00; cyc(); cyc();
    exp_rd("t2_pend_lat", 2'd0, 32'h01, FULL);
    exp_o("t2_hwint_lat", 2, 0); exp_o("t2_irq_lat", 0, 0); cyc();
    exp_o("t2_hwint", 2, 32'h01); exp_o("t2_irq", 0, 1); exp_o("t2_irq_id", 1, 0);
    wr(2'd0, 32'h01);
    exp_rd("t2_pend_w1c", 2'd0, 0, FULL); exp_o("t2_irq_hold", 0, 1); cyc();
    exp_o("t2_irq_drop", 0, 0); exp_o("t2_hwint_drop", 2, 0);
    exp_rd("t2_idle", 2'd3, 0, STM); cyc();

    // T3: two simultaneous edges, ack, EOI, re-arbitration
    wr(2'd2, 32'h3F); wr(2'd1, 32'h3F);
    src = 6'h0A; cyc(); src = 6'h00; cyc(); cyc(); cyc();
    exp_o("t3_irq", 0, 1); exp_o("t3_irq_id", 1, 1); exp_o("t3_hwint", 2, 32'h0A); cyc();
    ack = 1'b1; cyc(); ack = 1'b0;
    exp_o("t3_irq_insvc", 0, 0); exp_o("t3_id_insvc", 1, 1);
    exp_rd("t3_eoi_read", 2'd3, 32'h201, FULL); cyc();
    wr(2'd3, 32'hDEAD_BEEF);
    exp_rd("t3_pend_eoi", 2'd0, 32'h08, FULL); exp_o("t3_irq_idle", 0, 0); cyc();
    exp_o("t3_irq_next", 0, 1); exp_o("t3_id_next", 1, 3); exp_o("t3_hwint_next", 2, 32'h08); cyc();
    ack = 1'b1; cyc(); ack = 1'b0;
    wr(2'd3, 32'h0);
    exp_rd("t3_pend_clear", 2'd0, 0, FULL); cyc();

    // T4: level source dropped before ack
    wr(2'd2, 32'h00); wr(2'd1, 32'h04);
    src = 6'h04; cyc(); cyc(); cyc(); cyc();
    exp_o("t4_irq", 0, 1); exp_o("t4_irq_id", 1, 2); cyc();
    src = 6'h00; cyc(); cyc(); cyc();
    exp_o("t4_irq_still", 0, 1); exp_rd("t4_pend_fell", 2'd0, 0, FULL); cyc();
    exp_o("t4_irq_fell", 0, 0); exp_o("t4_hwint_fell", 2, 0);
    exp_rd("t4_idle", 2'd3, 0, STM); cyc();

    // T5: edge set beats same-cycle W1C; stray ack in IDLE
    wr(2'd1, 32'h00); wr(2'd2, 32'h10);
    src = 6'h10; cyc(); src = 6'h00; cyc(); cyc();
    exp_rd("t5_pend_set", 2'd0, 32'h10, FULL);
    src = 6'h10; cyc(); src = 6'h00; cyc();
    wr(2'd0, 32'h10);
    exp_rd("t5_set_wins", 2'd0, 32'h10, FULL); cyc();
    wr(2'd0, 32'h10);
    exp_rd("t5_w1c", 2'd0, 0, FULL); cyc();
    ack = 1'b1; cyc(); ack = 1'b0;
    exp_o("t5_irq_ack_idle", 0, 0); exp_rd("t5_state_ack_idle", 2'd3, 0, STM); cyc();

    // T6: asynchronous reset while in service
    wr(2'd2, 32'h02); wr(2'd1, 32'h02);
    src = 6'h02; cyc(); src = 6'h00; cyc(); cyc(); cyc();
    ack = 1'b1; cyc(); ack = 1'b0;
    exp_o("t6_pre_id", 1, 1); exp_o("t6_pre_hwint", 2, 32'h02);
    exp_rd("t6_pre_state", 2'd3, 32'h201, FULL); cyc();
    reset = 1'b0;
    bus.addr = 2'd0;
    exp_o("t6_rst_irq", 0, 0); exp_o("t6_rst_id", 1, 0); exp_o("t6_rst_hwint", 2, 0);
    exp_rd("t6_rst_pend", 2'd0, 0, FULL);
    @(negedge clk); #1;
    reset = 1'b1;
    cyc();
    exp_rd("t6_idle", 2'd3, 0, FULL); exp_o("t6_irq", 0, 0); cyc();

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
